bt_clear_ctrl: RTL
==================

Name: bt_clear_ctrl

Overview:
- Source end of the Borrowed-Time clear/rnd interface consumed by the masked BT state registers.
- Watches an attack-alarm input and drives a registered `clear` pulse train to wipe masked state.
- Holds the cipher core in abort during recovery and supplies per-cycle fresh randomness on `rnd` from an internal 32-bit LFSR.
- Sits between the alarm sensor logic and every BT register bank in the masked core.

Parameters:
- count, 1, width of `rnd` bus (one bit per protected register slice); legal range 1..32.
- CLEAR_CYCLES, 4, number of consecutive cycles `clear` is held per wipe; minimum 1.
- HOLDOFF, 16, cycles after a wipe before the core is released; minimum 1.
- MAX_ALARMS, 3, alarm count at which the block locks permanently; range 1..255.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- alarm  input  1  attack detected; level-sensitive, sampled each cycle.
- seed_valid  input  1  load `seed` into the LFSR this cycle.
- seed  input  32  LFSR seed value.
- rnd  output  count  fresh randomness, equal to `lfsr[count-1:0]`.
- clear  output  1  wipe request to BT registers; registered.
- core_abort  output  1  core must discard current operation; registered.
- ready  output  1  core may run (state RUN); registered.
- locked  output  1  permanent lockout reached; registered.
- alarm_cnt  output  8  number of accepted alarms, saturating at 255.

Behaviour:
- Reset (async, `rst_n=0`):
  - state=WIPE, timer=CLEAR_CYCLES-1.
  - clear=1, core_abort=1, ready=0, locked=0, alarm_cnt=0, lfsr=32'h0000_0001.
  - The block therefore wipes on every reset release.
- LFSR:
  - Fibonacci, polynomial x^32+x^22+x^2+x+1; advances every cycle in every state, including LOCK.
  - `seed_valid=1` loads `seed` instead of advancing.
  - A zero seed loads 32'h0000_0001.
  - `rnd` changes every cycle.
- Alarm acceptance:
  - An alarm is accepted when `alarm=1` is sampled in RUN, WIPE or HOLD.
  - Each acceptance increments `alarm_cnt` (saturating) and restarts a wipe.
  - When the incremented count reaches MAX_ALARMS, the next state is LOCK instead of WIPE.
- States (outputs are registered and reflect the current state):
  - WIPE:
    - clear=1, core_abort=1, ready=0.
    - timer counts down to 0, then HOLD with timer=HOLDOFF-1.
    - An alarm in WIPE reloads timer=CLEAR_CYCLES-1 and stays in WIPE.
  - HOLD:
    - clear=0, core_abort=1, ready=0.
    - timer counts down to 0, then RUN.
    - An alarm goes to WIPE.
  - RUN:
    - clear=0, core_abort=0, ready=1.
    - An alarm goes to WIPE (or LOCK).
  - LOCK:
    - clear=1, core_abort=1, ready=0, locked=1.
    - Exited only by reset; alarms are ignored and the count is frozen.
- Latency:
  - An alarm sampled high at edge k gives clear=1, core_abort=1 and ready=0 from edge k+1.
  - One wipe-to-run sequence with no further alarms lasts CLEAR_CYCLES+HOLDOFF cycles.
- Simultaneous events:
  - `seed_valid` and an alarm in the same cycle are both honoured.
  - An alarm on the final WIPE or HOLD cycle takes priority over the timer-expiry transition.
- Reset mid-wipe or in LOCK returns to the reset state immediately, without waiting for a clock edge.

Optional Feature:
- Macro: BT_ALARM_SYNC_EN.
- Defined:
  - `alarm` passes through a 2-flop synchroniser (reset to 0) before acceptance.
  - Alarm-to-clear latency becomes 3 edges.
  - A pulse shorter than one cycle may be missed.
- Undefined:
  - `alarm` is used directly; latency is 1 edge.
  - `alarm` must be synchronous to `clk`.

Test Plan:
- Reset, release, no alarm, CLEAR_CYCLES=4, HOLDOFF=16 -> clear=1 for 4 cycles, core_abort=1 for 20 cycles, ready=1 at cycle 20; alarm_cnt=0.
- In RUN, 1-cycle alarm -> clear=1 next cycle for 4 cycles, ready returns after 20 cycles, alarm_cnt=1.
- Alarm asserted during HOLD cycle 10 -> returns to WIPE, 4 more clear cycles, alarm_cnt=2, total recovery restarts.
- Three alarms with MAX_ALARMS=3 -> locked=1, clear=1 permanently; a further 100 alarm cycles leave alarm_cnt=3; rst_n pulse clears all.
- seed_valid with seed=0 -> next lfsr=1; seed=32'hDEADBEEF -> rnd (count=8) equals 8'hEF the next cycle, then follows the polynomial against a reference model for 1000 cycles with no all-zero state.
- With BT_ALARM_SYNC_EN: alarm at edge k -> clear rises at edge k+3; without the macro, at edge k+1.

Source files
------------

// File: rtl/bt_clear_ctrl.sv
// bt_clear_ctrl: alarm-driven clear/abort sequencer and LFSR randomness for BT register banks.
// Ports: clk, rst_n, alarm, seed_valid, seed -> rnd, clear, core_abort, ready, locked, alarm_cnt. Option: BT_ALARM_SYNC_EN.
module bt_clear_ctrl #(
  parameter int count        = 1,
  parameter int CLEAR_CYCLES = 4,
  parameter int HOLDOFF      = 16,
  parameter int MAX_ALARMS   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alarm,
  input  logic             seed_valid,
  input  logic [31:0]      seed,
  output logic [count-1:0] rnd,
  output logic             clear,
  output logic             core_abort,
  output logic             ready,
  output logic             locked,
  output logic [7:0]       alarm_cnt
);

  localparam int TMAX = (CLEAR_CYCLES > HOLDOFF) ?
                        CLEAR_CYCLES : HOLDOFF;
  localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] T_CLR = TW'(CLEAR_CYCLES - 1);
  localparam logic [TW-1:0] T_HLD = TW'(HOLDOFF - 1);

  typedef enum logic [1:0] {
    S_WIPE,
    S_HOLD,
    S_RUN,
    S_LOCK
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    cnt_q, cnt_d, cnt_inc;
  logic [31:0]   lfsr_q, lfsr_d;
  logic          alarm_in;
  logic          accept;
  logic          fb;

`ifdef BT_ALARM_SYNC_EN
  logic sync_q1, sync_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= alarm;
      sync_q2 <= sync_q1;
    end
  end

  assign alarm_in = sync_q2;
`else
  assign alarm_in = alarm;
`endif

  // taps 32,22,2,1
  assign fb = lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0];

  always_comb begin
    lfsr_d = {lfsr_q[30:0], fb};
    if (seed_valid) begin
      lfsr_d = (seed == 32'h0) ? 32'h1 : seed;
    end
  end

  assign accept  = alarm_in && (state_q != S_LOCK);
  assign cnt_inc = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;

  // an accepted alarm overrides any timer expiry in the same cycle
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    if (accept) begin
      cnt_d = cnt_inc;
      if (int'(cnt_inc) >= MAX_ALARMS) begin
        state_d = S_LOCK;
      end else begin
        state_d = S_WIPE;
        timer_d = T_CLR;
      end
    end else begin
      unique case (state_q)
        S_WIPE: begin
          if (timer_q == '0) begin
            state_d = S_HOLD;
            timer_d = T_HLD;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        S_HOLD: begin
          if (timer_q == '0) begin
            state_d = S_RUN;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        S_RUN:  state_d = S_RUN;
        S_LOCK: state_d = S_LOCK;
        default: state_d = S_LOCK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_WIPE;
      timer_q    <= T_CLR;
      cnt_q      <= 8'd0;
      lfsr_q     <= 32'h1;
      clear      <= 1'b1;
      core_abort <= 1'b1;
      ready      <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      lfsr_q     <= lfsr_d;
      clear      <= (state_d == S_WIPE) || (state_d == S_LOCK);
      core_abort <= (state_d != S_RUN);
      ready      <= (state_d == S_RUN);
      locked     <= (state_d == S_LOCK);
    end
  end

  assign alarm_cnt = cnt_q;
  assign rnd       = lfsr_q[count-1:0];

endmodule
